multicycle_control: RTL and testbench

Multi-cycle control unit for the processor datapath. It sequences instruction fetch, decode, execute, memory access and writeback over a single shared memory port with a req/ready handshake. It drives the register-file, ALU, PC and IR enables, and drives the immediate extensor's class select from the decoded opcode. It sits between the instruction register and the datapath muxes, and is the only block that issues memory requests.

---
 rtl/multicycle_control_if.sv | 9 +
 rtl/multicycle_control.sv | 78 +++++++
 tb/tb_multicycle_control.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: shared memory port handshake between the controller and memory.
interface multicycle_control_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;
  modport master (output mem_req, mem_we, mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing fetch/decode/execute/memory/writeback over one shared memory port.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic [31:0]                 instruction,
  input  logic                        alu_zero,
  multicycle_control_if.master        mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        pc_src,
  output logic                        alu_src_imm,
  output logic                        reg_write,
  output logic                        wb_sel,
  output logic [1:0]                  imm_sel,
  output logic                        retire,
  output logic [31:0]                 retired_count,
  output logic                        halt
);
  localparam logic [3:0] IDLE        = 4'd0;
  localparam logic [3:0] FETCH       = 4'd1;
  localparam logic [3:0] DECODE      = 4'd2;
  localparam logic [3:0] EXEC_ARITH  = 4'd3;
  localparam logic [3:0] WB_ALU      = 4'd4;
  localparam logic [3:0] EXEC_ADDR   = 4'd5;
  localparam logic [3:0] MEM_RD      = 4'd6;
  localparam logic [3:0] WB_MEM      = 4'd7;
  localparam logic [3:0] MEM_WR      = 4'd8;
  localparam logic [3:0] EXEC_BRANCH = 4'd9;
  localparam logic [3:0] TRAP        = 4'd10;
  logic [3:0] state, next;
  logic [3:0] opcode;
  logic       unused_ok;
  assign opcode    = instruction[31:28];
  assign unused_ok = ^instruction[26:0];
  always_comb begin
    next = state;
    case (state)
      IDLE:        next = run ? FETCH : IDLE;
      FETCH:       next = mem.mem_ready ? DECODE : FETCH;
      DECODE:      next = opcode == 4'b0000 ? EXEC_ADDR :
                          opcode == 4'b0001 ? EXEC_ARITH :
                          opcode == 4'b0111 ? EXEC_BRANCH : TRAP;
      EXEC_ARITH:  next = WB_ALU;
      EXEC_ADDR:   next = instruction[27] ? MEM_WR : MEM_RD;
      MEM_RD:      next = mem.mem_ready ? WB_MEM : MEM_RD;
      MEM_WR:      next = mem.mem_ready ? FETCH : MEM_WR;
      WB_ALU, WB_MEM, EXEC_BRANCH: next = FETCH;
      default:     next = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      retired_count <= '0;
    end else begin
      state <= next;
      if (retire) retired_count <= retired_count + 32'd1;
    end
  end
  // Moore outputs, except the handshake-gated fetch/store strobes and the branch condition
  assign mem.mem_req      = state == FETCH || state == MEM_RD || state == MEM_WR;
  assign mem.mem_we       = state == MEM_WR;
  assign mem.mem_addr_sel = state == MEM_RD || state == MEM_WR;
  assign ir_write         = state == FETCH && mem.mem_ready;
  assign pc_write         = (state == FETCH && mem.mem_ready) ||
                            (state == EXEC_BRANCH && (!instruction[27] || alu_zero));
  assign pc_src           = state == EXEC_BRANCH;
  assign alu_src_imm      = state == EXEC_ARITH || state == EXEC_ADDR || state == EXEC_BRANCH;
  assign reg_write        = state == WB_ALU || state == WB_MEM;
  assign wb_sel           = state == WB_MEM;
  assign retire           = state == WB_ALU || state == WB_MEM || state == EXEC_BRANCH ||
                            (state == MEM_WR && mem.mem_ready);
  assign halt             = state == TRAP;
  assign imm_sel          = opcode == 4'b0000 ? 2'b00 :
                            opcode == 4'b0001 ? 2'b01 :
                            opcode == 4'b0111 ? 2'b10 : 2'b11;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-cycle checks of the multicycle controller outputs.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [31:0] instruction = '0;
  logic        alu_zero = 1'b0;
  logic        ir_write, pc_write, pc_src, alu_src_imm, reg_write, wb_sel, retire, halt;
  logic [1:0]  imm_sel;
  logic [31:0] retired_count;
  logic [10:0] outs;
  int          checks = 0;
  int          errors = 0;

  multicycle_control_if mem ();

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instruction(instruction), .alu_zero(alu_zero),
    .mem(mem), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .wb_sel(wb_sel), .imm_sel(imm_sel),
    .retire(retire), .retired_count(retired_count), .halt(halt)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_imm, reg_write, wb_sel, retire, halt}
  assign outs = {mem.mem_req, mem.mem_we, mem.mem_addr_sel, ir_write, pc_write, pc_src,
                 alu_src_imm, reg_write, wb_sel, retire, halt};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mem.mem_ready = 1'b0;
    #1;
    checks++;
    if (outs !== 11'h000 || retired_count !== 32'd0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_init outs=%h cnt=%0d exp outs=000 cnt=0", outs, retired_count);
    end
  endtask

  task automatic test_arith();
    logic [10:0] e [10];
    logic [9:0]  rdy;
    e   = '{11'h000, 11'h4C0, 11'h000, 11'h010, 11'h00A, 11'h4C0, 11'h000, 11'h010, 11'h00A, 11'h400};
    rdy = 10'b0111111111;
    do_reset();
    instruction = 32'h18000AAA;
    for (int i = 0; i < 10; i++) begin
      run = (i == 0);
      mem.mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL arith c%0d outs=%h exp=%h", i, outs, e[i]);
      end
      if (i == 3) begin
        checks++;
        if (imm_sel !== 2'b01) begin
          errors++;
          $display("FAIL arith_imm_sel got=%b exp=01", imm_sel);
        end
      end
      if (i == 5 || i == 9) begin
        checks++;
        if (retired_count !== (i == 5 ? 32'd1 : 32'd2)) begin
          errors++;
          $display("FAIL arith_count c%0d got=%0d exp=%0d", i, retired_count, i == 5 ? 1 : 2);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_fetch();
    mem.mem_ready = 1'b0;
    #1;
    checks++;
    if (mem.mem_req !== 1'b1 || retired_count !== 32'd2) begin
      errors++;
      $display("FAIL pre_reset mem_req=%b cnt=%0d exp mem_req=1 cnt=2", mem.mem_req, retired_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 11'h000 || retired_count !== 32'd0 || halt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset outs=%h cnt=%0d exp outs=000 cnt=0", outs, retired_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    mem.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs !== 11'h000) begin
        errors++;
        $display("FAIL idle_hold c%0d outs=%h exp=000", i, outs);
      end
    end
  endtask

  task automatic test_load_wait();
    logic [10:0] e [11];
    logic [10:0] rdy;
    e   = '{11'h000, 11'h400, 11'h400, 11'h4C0, 11'h000, 11'h010,
            11'h500, 11'h500, 11'h500, 11'h00E, 11'h400};
    rdy = 11'b01100111001;
    do_reset();
    instruction = 32'h00000AAA;
    for (int i = 0; i < 11; i++) begin
      run = (i == 0);
      mem.mem_ready = rdy[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL load c%0d outs=%h exp=%h", i, outs, e[i]);
      end
      if (i == 4) begin
        checks++;
        if (imm_sel !== 2'b00) begin
          errors++;
          $display("FAIL load_imm_sel got=%b exp=00", imm_sel);
        end
      end
      if (i == 10) begin
        checks++;
        if (retired_count !== 32'd1) begin
          errors++;
          $display("FAIL load_count got=%0d exp=1", retired_count);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    logic [10:0] e [6];
    e = '{11'h000, 11'h4C0, 11'h000, 11'h010, 11'h702, 11'h4C0};
    do_reset();
    instruction = 32'h08000AAA;
    for (int i = 0; i < 6; i++) begin
      run = (i == 0);
      mem.mem_ready = 1'b1;
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL store c%0d outs=%h exp=%h", i, outs, e[i]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (retired_count !== 32'd1) begin
      errors++;
      $display("FAIL store_count got=%0d exp=1", retired_count);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [3];
    logic [2:0]  zero;
    logic [10:0] ex3 [3];
    logic [10:0] e;
    ins  = '{32'h78001000, 32'h78001000, 32'h70001000};
    zero = 3'b010;
    ex3  = '{11'h032, 11'h072, 11'h072};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      instruction = ins[k];
      alu_zero = zero[k];
      for (int i = 0; i < 5; i++) begin
        run = (i == 0);
        mem.mem_ready = 1'b1;
        #1;
        e = i == 3 ? ex3[k] : (i == 1 || i == 4) ? 11'h4C0 : 11'h000;
        checks++;
        if (outs !== e) begin
          errors++;
          $display("FAIL branch%0d c%0d outs=%h exp=%h", k, i, outs, e);
        end
        if (i == 3) begin
          checks++;
          if (imm_sel !== 2'b10) begin
            errors++;
            $display("FAIL branch%0d_imm_sel got=%b exp=10", k, imm_sel);
          end
        end
        @(negedge clk);
      end
    end
    alu_zero = 1'b0;
  endtask

  task automatic test_trap();
    logic [10:0] e;
    do_reset();
    instruction = 32'hF8001000;
    for (int i = 0; i < 8; i++) begin
      run = 1'b1;
      mem.mem_ready = 1'b1;
      #1;
      e = i == 0 ? 11'h000 : i == 1 ? 11'h4C0 : i == 2 ? 11'h000 : 11'h001;
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL trap c%0d outs=%h exp=%h", i, outs, e);
      end
      @(negedge clk);
    end
    checks++;
    if (imm_sel !== 2'b11 || retired_count !== 32'd0) begin
      errors++;
      $display("FAIL trap_imm_cnt imm_sel=%b cnt=%0d exp imm_sel=11 cnt=0", imm_sel, retired_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 11'h000) begin
      errors++;
      $display("FAIL trap_reset outs=%h exp=000", outs);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_reset_mid_fetch();
    test_load_wait();
    test_store();
    test_branch();
    test_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
